muldiv_sequencer: RTL
=====================

// Module: muldiv_sequencer
// PURPOSE
//  Multi-cycle controller plus iterative datapath for RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
//  Sits in EX beside the main ALU and takes operands after forwarding.
//  Holds the pipeline through stall while it iterates, then returns the result for a single cycle.
// PARAMETERS
//  XLEN  32  operand/result width; the iteration count equals XLEN
// PORTS
//  clk     in   1     clock; every flop updates on the rising edge
//  rst     in   1     synchronous, active-high reset
//  start   in   1     EX holds an M-ext op; held high by pipeline until done
//  func3   in   3     M-ext op select (F3_MUL..F3_REMU in defines.v)
//  op_a    in   XLEN  rs1 value (dividend / multiplicand)
//  op_b    in   XLEN  rs2 value (divisor / multiplier)
//  flush   in   1     EX flush (branch/jump redirect); aborts current op
//  stall   out  1     freeze PC, IF/ID, ID/EX
//  busy    out  1     FSM not IDLE
//  done    out  1     one-cycle pulse; result valid this cycle
//  result  out  XLEN  final value; held until next done
// BEHAVIOUR
//  - Reset: rst=1 at a clock edge -> state IDLE. At reset, done=0, result=0, busy=0 and stall=0.
//    This also applies mid-operation; no done is produced for the aborted op.
//  - States: IDLE, MUL, DIV, DONE.
//  - Start (IDLE, start=1 at cycle T): latch operand magnitudes, sign flags and func3.
//    - func3[2]=0 -> MUL.
//    - func3[2]=1 -> DIV, except the special cases below, which go directly to DONE.
//  - MUL/DIV: one iteration per cycle with a 6-bit counter running 0..XLEN-1.
//    Leave for DONE after iteration XLEN-1.
//    Normal latency: done at T+XLEN+1 (T+33 for XLEN=32).
//  - DONE: done=1, result is driven, stall=0 so the pipeline advances.
//    Always go to IDLE next, even if start is still 1; never retrigger on the same op.
//  - stall = (state==IDLE & start & ~flush) | state==MUL | state==DIV.
//  - busy = state != IDLE.
//  - flush=1 in any state -> IDLE next cycle with no done. flush takes priority over start and iteration.
//  - start in MUL/DIV/DONE is ignored; operands and func3 are sampled only in IDLE.
//  - Multiply: unsigned shift-add on magnitudes into a 2*XLEN product.
//    - Signedness: MUL/MULH = s*s, MULHSU = s*u, MULHU = u*u.
//    - Negate the product if the operand signs differ (signed operands only).
//    - MUL returns the low XLEN bits; the others return the high XLEN bits.
//  - Divide: restoring divide on magnitudes, one quotient bit per cycle.
//    - Quotient sign = sa^sb (DIV only).
//    - Remainder sign = sa (REM only).
//    - Unsigned ops never negate.
//  - Special cases, decided in IDLE; done at T+1:
//    - op_b=0: DIV/DIVU return all-ones; REM/REMU return op_a.
//    - Signed overflow (op_a=0x80000000, op_b=-1): DIV returns 0x80000000; REM returns 0.
//  - All arithmetic wraps modulo 2^XLEN. No exceptions are raised.
// CONFIGURATION
//  `MULDIV_FAST_MUL_EN defined: multiply ops use a combinational 2*XLEN multiplier.
//    They go IDLE->DONE with done at T+1; the MUL state is unused.
//  Undefined: iterative shift-add as described above, XLEN+1 cycle latency.
//  Divide behaviour is identical in both builds.
// STRUCTURE
//  defines.v (shared) holds:
//    - F3_MUL..F3_REMU func3 codes
//    - MD_IDLE/MD_MUL/MD_DIV/MD_DONE state encodings (2 bits)
//    - ALUOP_MULDIV, the control-unit code that raises start
//  One sub-module, muldiv_iter_core: the shift/add-subtract datapath (remainder, quotient and product registers).
//    It exposes step/init/is_div and the raw magnitudes.
//  The FSM, sign fix-up, special cases and handshake stay in muldiv_sequencer.
// TESTING
//  1. MUL 7*(-3): start=1 held -> stall=1 for 33 cycles; done at T+33 with result=0xFFFFFFEB.
//  2. MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
//  3. DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//     Each has done at T+33.
//  4. Special cases, done at T+1 with stall high for exactly 1 cycle:
//     - DIV 5/0 -> 0xFFFFFFFF
//     - REMU 5/0 -> 5
//     - DIV 0x80000000/-1 -> 0x80000000
//     - REM of the same operands -> 0
//  5. Abort paths:
//     - flush at T+10 of a DIV -> IDLE at T+11, no done, busy=0.
//     - Same with rst=1 instead of flush -> all outputs 0 next cycle.
//     - start held through DONE -> exactly one done pulse.
//  6. Build with `MULDIV_FAST_MUL_EN: MULHSU -1*3 -> 0xFFFFFFFF with done at T+1.
//     DIVU latency is unchanged at T+33.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
// Shared RV32M sequencer definitions: func3 codes, FSM state encoding, operand sign helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package muldiv_sequencer_pkg;

   // M-extension func3 codes
   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   // Control-unit ALU op code that raises start toward the sequencer
   localparam logic [3:0] ALUOP_MULDIV = 4'hA;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_MUL  = 2'd1,
      MD_DIV  = 2'd2,
      MD_DONE = 2'd3
   } md_state_e;

   // rs1 is treated as signed for everything except MULHU/DIVU/REMU
   function automatic logic f3_a_signed(input logic [2:0] f3);
      return (f3 != F3_MULHU) && (f3 != F3_DIVU) && (f3 != F3_REMU);
   endfunction

   // rs2 is signed only for MUL/MULH/DIV/REM (MULHSU takes it unsigned)
   function automatic logic f3_b_signed(input logic [2:0] f3);
      return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// EX-stage handshake bundle between the pipeline and the mul/div sequencer.
// Latency: n/a (wires only).
// Backpressure: sequencer raises stall while iterating; pipeline holds start/operands until done.
// Ports: start/func3/op_a/op_b/flush driven by the pipeline (master);
//        stall/busy/done/result driven by the sequencer (slave).
interface muldiv_sequencer_if #(
   parameter int XLEN = 32
) ();
   logic            start;
   logic [2:0]      func3;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic            flush;
   logic            stall;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output start, func3, op_a, op_b, flush,
      input  stall, busy, done, result
   );

   modport slave (
      input  start, func3, op_a, op_b, flush,
      output stall, busy, done, result
   );
endinterface

// File: rtl/muldiv_iter_core.sv
// Iterative datapath: shift-add multiply and restoring divide on unsigned magnitudes, one bit per step.
// Latency: one step per cycle; *_nxt outputs show the value the current step produces.
// Backpressure: none; advances only when the controller asserts step.
// Ports: init loads mag_a/mag_b; step advances the product (is_div=0) or quotient/remainder (is_div=1).
module muldiv_iter_core #(
   parameter int XLEN = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              init,
   input  logic              step,
   input  logic              is_div,
   input  logic [XLEN-1:0]   mag_a,
   input  logic [XLEN-1:0]   mag_b,
   output logic [2*XLEN-1:0] prod_nxt,
   output logic [XLEN-1:0]   quo_nxt,
   output logic [XLEN-1:0]   rem_nxt
);

   logic [XLEN-1:0]   mcand_q, mcand_d;
   logic [XLEN-1:0]   dvsr_q,  dvsr_d;
   logic [XLEN-1:0]   quo_q,   quo_d;
   logic [XLEN-1:0]   rem_q,   rem_d;
   logic [2*XLEN-1:0] prod_q,  prod_d;

   logic [XLEN:0] acc_sum;
   logic [XLEN:0] rem_shift;
   logic [XLEN:0] rem_diff;

   always_comb begin
      // Multiply: low half holds the unconsumed multiplier bits; add into the high half, then shift right
      acc_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
      prod_nxt = {acc_sum, prod_q[XLEN-1:1]};

      // Divide: quotient register starts as the dividend and is shifted out into the remainder
      rem_shift = {rem_q, quo_q[XLEN-1]};
      rem_diff  = rem_shift - {1'b0, dvsr_q};
      quo_nxt   = {quo_q[XLEN-2:0], ~rem_diff[XLEN]};
      rem_nxt   = rem_diff[XLEN] ? rem_shift[XLEN-1:0] : rem_diff[XLEN-1:0];

      mcand_d = mcand_q;
      dvsr_d  = dvsr_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      prod_d  = prod_q;
      if (init) begin
         mcand_d = mag_a;
         dvsr_d  = mag_b;
         prod_d  = {{XLEN{1'b0}}, mag_b};
         quo_d   = mag_a;
         rem_d   = '0;
      end else if (step) begin
         if (is_div) begin
            quo_d = quo_nxt;
            rem_d = rem_nxt;
         end else begin
            prod_d = prod_nxt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mcand_q <= '0;
         dvsr_q  <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         prod_q  <= '0;
      end else begin
         mcand_q <= mcand_d;
         dvsr_q  <= dvsr_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         prod_q  <= prod_d;
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle controller: FSM, sign fix-up, divide special cases and pipeline handshake.
// Latency: done at T+XLEN+1 for iterative ops; T+1 for divide special cases (and multiplies with MULDIV_FAST_MUL_EN).
// Backpressure: stall held from the start cycle until the op completes; flush aborts silently.
// Ports: clk, rst (sync, active high), md (slave side of muldiv_sequencer_if).
// Build option: define MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier.
module muldiv_sequencer
   import muldiv_sequencer_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic              clk,
   input  logic              rst,
   muldiv_sequencer_if.slave md
);

   localparam logic [5:0] LAST_CNT = 6'(XLEN - 1);

   md_state_e       state_q, state_d;
   logic [5:0]      cnt_q, cnt_d;
   logic [2:0]      func3_q, func3_d;
   logic            neg_q, neg_d;      // product / quotient negate
   logic            sa_q, sa_d;        // remainder negate (follows dividend sign)
   logic            done_q, done_d;
   logic            busy_q, busy_d;
   logic [XLEN-1:0] result_q, result_d;

   logic            sa, sb;
   logic            div_by_zero, div_ovf;
   logic            core_init, core_step;
   logic [XLEN-1:0] mag_a, mag_b, special_res;
   logic [2*XLEN-1:0] prod_nxt;
   logic [XLEN-1:0] quo_nxt, rem_nxt;

   function automatic logic [XLEN-1:0] mul_fix(input logic [2*XLEN-1:0] prod,
                                               input logic [2:0] f3, input logic neg);
      logic [2*XLEN-1:0] p;
      p = neg ? -prod : prod;
      return (f3 == F3_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
   endfunction

   // Operand decode, only meaningful while IDLE
   always_comb begin
      sa          = f3_a_signed(md.func3) & md.op_a[XLEN-1];
      sb          = f3_b_signed(md.func3) & md.op_b[XLEN-1];
      mag_a       = sa ? -md.op_a : md.op_a;
      mag_b       = sb ? -md.op_b : md.op_b;
      div_by_zero = (md.op_b == '0);
      div_ovf     = ~md.func3[0] & (md.op_a == {1'b1, {(XLEN-1){1'b0}}}) & (&md.op_b);
      if (div_by_zero) special_res = md.func3[1] ? md.op_a : '1;
      else             special_res = md.func3[1] ? '0 : md.op_a;
   end

`ifdef MULDIV_FAST_MUL_EN
   logic [2*XLEN-1:0] fast_prod;
   always_comb begin
      fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
   end
`endif

   assign core_init = (state_q == MD_IDLE) & md.start & ~md.flush;
   assign core_step = ((state_q == MD_MUL) | (state_q == MD_DIV)) & ~md.flush;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      func3_d  = func3_q;
      neg_d    = neg_q;
      sa_d     = sa_q;
      result_d = result_q;

      unique case (state_q)
         MD_IDLE: begin
            if (md.start) begin
               func3_d = md.func3;
               neg_d   = sa ^ sb;
               sa_d    = sa;
               cnt_d   = '0;
               if (md.func3[2] && (div_by_zero || div_ovf)) begin
                  state_d  = MD_DONE;
                  result_d = special_res;
               end else if (md.func3[2]) begin
                  state_d = MD_DIV;
               end else begin
`ifdef MULDIV_FAST_MUL_EN
                  state_d  = MD_DONE;
                  result_d = mul_fix(fast_prod, md.func3, sa ^ sb);
`else
                  state_d  = MD_MUL;
`endif
               end
            end
         end
         MD_MUL, MD_DIV: begin
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == LAST_CNT) begin
               // Final iteration: the core's step outputs already hold the full result
               state_d = MD_DONE;
               if (state_q == MD_MUL)  result_d = mul_fix(prod_nxt, func3_q, neg_q);
               else if (func3_q[1])    result_d = sa_q  ? -rem_nxt : rem_nxt;
               else                    result_d = neg_q ? -quo_nxt : quo_nxt;
            end
         end
         MD_DONE: begin
            state_d = MD_IDLE;
         end
         default: state_d = MD_IDLE;
      endcase

      // Abort wins over start and iteration; the last good result stays visible
      if (md.flush) begin
         state_d  = MD_IDLE;
         result_d = result_q;
      end

      done_d = (state_d == MD_DONE);
      busy_d = (state_d != MD_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= MD_IDLE;
         cnt_q    <= '0;
         func3_q  <= '0;
         neg_q    <= 1'b0;
         sa_q     <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         func3_q  <= func3_d;
         neg_q    <= neg_d;
         sa_q     <= sa_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         result_q <= result_d;
      end
   end

   muldiv_iter_core #(.XLEN(XLEN)) u_core (
      .clk      (clk),
      .rst      (rst),
      .init     (core_init),
      .step     (core_step),
      .is_div   (state_q == MD_DIV),
      .mag_a    (mag_a),
      .mag_b    (mag_b),
      .prod_nxt (prod_nxt),
      .quo_nxt  (quo_nxt),
      .rem_nxt  (rem_nxt)
   );

   // Stall must cover the start cycle itself, so it is decoded from live inputs
   assign md.stall  = ((state_q == MD_IDLE) & md.start & ~md.flush) |
                      (state_q == MD_MUL) | (state_q == MD_DIV);
   assign md.busy   = busy_q;
   assign md.done   = done_q;
   assign md.result = result_q;

endmodule
